reg_cmd_ctrl: RTL and testbench

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

---
 rtl/sys_ctrl_pkg.sv | 31 +++
 rtl/reg_cmd_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the register/command controller.
// Contents:
//   - command byte codes received over the RX byte stream
//   - controller FSM state encoding
// The ALU states are always part of the encoding; the controller only
// reaches them when built with ALU_CMD_EN defined.
package sys_ctrl_pkg;

  localparam logic [7:0] CmdWrite  = 8'hAA;
  localparam logic [7:0] CmdRead   = 8'hBB;
  localparam logic [7:0] CmdAluOp  = 8'hCC;  // ALU with two operand bytes
  localparam logic [7:0] CmdAluNop = 8'hDD;  // ALU on operands already stored

  localparam logic [3:0] AluFunWidth = 4'd4;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StTxRd,
    StAluOpa,
    StAluOpb,
    StAluFunc,
    StAluWait,
    StTxLo,
    StTxHi
  } state_e;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Command controller: decodes a byte stream into register-file writes/reads
// and optional ALU operations, and returns results into a transmit FIFO.
//
// Build option: ALU_CMD_EN
//   defined   -> commands 0xCC/0xDD supported, ALU ports present
//   undefined -> ALU states/ports removed, 0xCC/0xDD dropped as unknown
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD      received byte and its one-cycle strobe
//   WrEn, RdEn, Address,     register-file access (all registered)
//   WrData
//   RdData, RdData_VLD       register-file read return
//   TX_P_DATA, TX_D_VLD      transmit-FIFO push, held off while TX_BUSY=1
//   TX_BUSY
//   ALU_EN, ALU_FUN          ALU start pulse and function (ALU_CMD_EN only)
//   ALU_OUT, ALU_OUT_VLD     ALU result return (ALU_CMD_EN only)
module reg_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ADDR  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   RX_P_DATA,
  input  logic               RX_D_VLD,
  output logic               WrEn,
  output logic               RdEn,
  output logic [ADDR-1:0]    Address,
  output logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH-1:0]   RdData,
  input  logic               RdData_VLD,
  output logic [WIDTH-1:0]   TX_P_DATA,
  output logic               TX_D_VLD,
  input  logic               TX_BUSY
`ifdef ALU_CMD_EN
  ,
  output logic               ALU_EN,
  output logic [3:0]         ALU_FUN,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_OUT_VLD
`endif
);

  // Latched result: one byte for reads, two bytes when the ALU is present.
`ifdef ALU_CMD_EN
  localparam int unsigned DataW = 2 * WIDTH;
`else
  localparam int unsigned DataW = WIDTH;
`endif

  state_e             state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               tx_vld_q, tx_vld_d;
  logic [ADDR-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [DataW-1:0]   data_q, data_d;
`ifdef ALU_CMD_EN
  logic               alu_en_q, alu_en_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    data_d    = data_q;
`ifdef ALU_CMD_EN
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
`endif

    case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(CmdWrite)) begin
            state_d = StWrAddr;
          end else if (RX_P_DATA == WIDTH'(CmdRead)) begin
            state_d = StRdAddr;
`ifdef ALU_CMD_EN
          end else if (RX_P_DATA == WIDTH'(CmdAluOp)) begin
            state_d = StAluOpa;
          end else if (RX_P_DATA == WIDTH'(CmdAluNop)) begin
            state_d = StAluFunc;
`endif
          end
          // Anything else is dropped and the controller stays idle.
        end
      end

      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = StWrData;
        end
      end

      StWrData: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          wr_data_d = RX_P_DATA;
          state_d   = StIdle;
        end
      end

      StRdAddr: begin
        if (RX_D_VLD) begin
          rd_en_d = 1'b1;
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = StRdWait;
        end
      end

      // Bytes arriving in the wait/transmit states are discarded.
      StRdWait: begin
        if (RdData_VLD) begin
          data_d  = DataW'(RdData);
          state_d = StTxRd;
        end
      end

      StTxRd: begin
        if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = data_q[WIDTH-1:0];
          state_d   = StIdle;
        end
      end

`ifdef ALU_CMD_EN
      // Operands land in fixed register-file slots 0 and 1.
      StAluOpa: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          addr_d    = '0;
          wr_data_d = RX_P_DATA;
          state_d   = StAluOpb;
        end
      end

      StAluOpb: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR'(1);
          wr_data_d = RX_P_DATA;
          state_d   = StAluFunc;
        end
      end

      StAluFunc: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[3:0];
          state_d   = StAluWait;
        end
      end

      StAluWait: begin
        if (ALU_OUT_VLD) begin
          data_d  = ALU_OUT;
          state_d = StTxLo;
        end
      end

      StTxLo: begin
        if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = data_q[WIDTH-1:0];
          state_d   = StTxHi;
        end
      end

      StTxHi: begin
        if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = data_q[2*WIDTH-1:WIDTH];
          state_d   = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      data_q    <= '0;
`ifdef ALU_CMD_EN
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      data_q    <= data_d;
`ifdef ALU_CMD_EN
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
`endif
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
`ifdef ALU_CMD_EN
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
`endif

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl. Build with ALU_CMD_EN defined to also
// exercise the ALU commands; otherwise 0xCC/0xDD are checked as dropped.
module tb_reg_cmd_ctrl;

  localparam int W = 8;
  localparam int A = 4;

  localparam int KW = 0;  // register write
  localparam int KR = 1;  // register read strobe
  localparam int KA = 2;  // ALU start
  localparam int KT = 3;  // transmit byte

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [W-1:0]   RX_P_DATA = '0;
  logic           RX_D_VLD = 1'b0;
  logic           WrEn, RdEn;
  logic [A-1:0]   Address;
  logic [W-1:0]   WrData;
  logic [W-1:0]   RdData = '0;
  logic           RdData_VLD = 1'b0;
  logic [W-1:0]   TX_P_DATA;
  logic           TX_D_VLD;
  logic           TX_BUSY = 1'b0;
`ifdef ALU_CMD_EN
  logic           ALU_EN;
  logic [3:0]     ALU_FUN;
  logic [2*W-1:0] ALU_OUT = '0;
  logic           ALU_OUT_VLD = 1'b0;
`endif

  reg_cmd_ctrl #(.WIDTH(W), .ADDR(A)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .WrEn       (WrEn),
    .RdEn       (RdEn),
    .Address    (Address),
    .WrData     (WrData),
    .RdData     (RdData),
    .RdData_VLD (RdData_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_BUSY    (TX_BUSY)
`ifdef ALU_CMD_EN
    ,
    .ALU_EN     (ALU_EN),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int a;
    int d;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rf[16];     // register file as seen by the DUT's writes
  logic [7:0] mem_m[16];  // reference model's register file
  logic       busy_at_edge = 1'b0;

  always @(posedge CLK) busy_at_edge <= TX_BUSY;

  function automatic void expect_ev(input int kind, input int a, input int d);
    exp_t e;
    e.kind = kind;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(input int kind, input int a, input int d, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event a=%0h d=%0h, required no event", name, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.d != d) begin
        errors++;
        $display("FAIL %s: got kind=%0d a=%0h d=%0h, required kind=%0d a=%0h d=%0h",
                 name, kind, a, d, e.kind, e.a, e.d);
      end
    end
  endfunction

  // Monitor: every output strobe must match the next expected event.
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn || RdEn) begin
        checks++;
        if (WrEn && RdEn) begin
          errors++;
          $display("FAIL wr_rd_exclusive: got WrEn=1 RdEn=1, required at most one");
        end
      end
      if (WrEn) begin
        rf[Address] = WrData;
        check_ev(KW, int'(Address), int'(WrData), "write");
      end
      if (RdEn) check_ev(KR, int'(Address), 0, "read_strobe");
`ifdef ALU_CMD_EN
      if (ALU_EN) check_ev(KA, int'(ALU_FUN), 0, "alu_start");
`endif
      if (TX_D_VLD) begin
        checks++;
        if (busy_at_edge) begin
          errors++;
          $display("FAIL tx_busy_gate: got TX_D_VLD after TX_BUSY=1, required TX_BUSY=0");
        end
        check_ev(KT, 0, int'(TX_P_DATA), "tx_byte");
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0;
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
`ifdef ALU_CMD_EN
    return b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD;
`else
    return b == 8'hAA || b == 8'hBB;
`endif
  endfunction

  function automatic logic [7:0] rand_noncmd();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_cmd(b));
    return b;
  endfunction

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, "_wren"}, int'(WrEn), 0);
    check_val({name, "_rden"}, int'(RdEn), 0);
    check_val({name, "_txvld"}, int'(TX_D_VLD), 0);
    check_val({name, "_addr"}, int'(Address), 0);
    check_val({name, "_wrdata"}, int'(WrData), 0);
    check_val({name, "_txdata"}, int'(TX_P_DATA), 0);
`ifdef ALU_CMD_EN
    check_val({name, "_aluen"}, int'(ALU_EN), 0);
    check_val({name, "_alufun"}, int'(ALU_FUN), 0);
`endif
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    expect_ev(KW, int'(a[3:0]), int'(d));
    mem_m[a[3:0]] = d;
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    drain("write_frame");
  endtask

  task automatic do_read(input logic [7:0] a, input int busy_cycles, input int junk);
    bit seen = 0;
    expect_ev(KR, int'(a[3:0]), 0);
    expect_ev(KT, 0, int'(mem_m[a[3:0]]));
    send_byte(8'hBB);
    send_byte(a);
    for (int i = 0; i < 50 && !seen; i++) begin
      if (RdEn) seen = 1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL read_wait: got no RdEn in 50 cycles, required RdEn");
    end else begin
      RdData = rf[Address];
      for (int j = 0; j < junk; j++) send_byte(8'($urandom_range(0, 255)));
      TX_BUSY = (busy_cycles > 0);
      RdData_VLD = 1'b1;
      tick();
      RdData_VLD = 1'b0;
      for (int j = 0; j < busy_cycles; j++) begin
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)));
        else tick();
      end
      TX_BUSY = 1'b0;
    end
    drain("read_frame");
  endtask

`ifdef ALU_CMD_EN
  task automatic do_alu(input bit with_ops, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [3:0] fun, input logic [15:0] val, input int busy_cycles);
    bit seen = 0;
    if (with_ops) begin
      expect_ev(KW, 0, int'(opa));
      expect_ev(KW, 1, int'(opb));
      mem_m[0] = opa;
      mem_m[1] = opb;
    end
    expect_ev(KA, int'(fun), 0);
    expect_ev(KT, 0, int'(val[7:0]));
    expect_ev(KT, 0, int'(val[15:8]));
    if (with_ops) begin
      send_byte(8'hCC);
      send_byte(opa);
      send_byte(opb);
    end else begin
      send_byte(8'hDD);
    end
    send_byte({4'($urandom_range(0, 15)), fun});
    for (int i = 0; i < 50 && !seen; i++) begin
      if (ALU_EN) seen = 1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL alu_wait: got no ALU_EN in 50 cycles, required ALU_EN");
    end else begin
      send_byte(8'($urandom_range(0, 255)));
      TX_BUSY = (busy_cycles > 0);
      ALU_OUT = val;
      ALU_OUT_VLD = 1'b1;
      tick();
      ALU_OUT_VLD = 1'b0;
      for (int j = 0; j < busy_cycles; j++) tick();
      TX_BUSY = 1'b0;
    end
    drain("alu_frame");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'h00;
      mem_m[i] = 8'h00;
    end
    tick();
    check_outputs_zero("reset");
    tick();
    RST = 1'b1;
    tick();

    // Directed cases.
    do_write(8'h05, 8'h3C);
    do_write(8'h02, 8'h21);
    do_read(8'h02, 0, 0);
    do_read(8'h02, 10, 2);
    send_byte(8'h55);
    do_write(8'h01, 8'hFF);
`ifdef ALU_CMD_EN
    do_alu(1, 8'h0A, 8'h03, 4'h0, 16'h000D, 0);
    do_alu(0, 8'h00, 8'h00, 4'h7, 16'hBEEF, 3);
`else
    send_byte(8'hCC);
    do_write(8'h03, 8'h77);
    send_byte(8'hDD);
    do_read(8'h03, 1, 1);
`endif

    // Reset in the middle of a write frame.
    send_byte(8'hAA);
    send_byte(8'h07);
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    tick();
    tick();
    RST = 1'b1;
    tick();
    do_read(8'h07, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
`ifdef ALU_CMD_EN
      int op = $urandom_range(0, 4);
`else
      int op = $urandom_range(0, 2);
`endif
      case (op)
        0: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        1: do_read(8'($urandom_range(0, 255)), $urandom_range(0, 4), $urandom_range(0, 2));
        2: begin
          send_byte(rand_noncmd());
          drain("dropped_byte");
        end
`ifdef ALU_CMD_EN
        3: do_alu(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 3));
        4: do_alu(0, 8'h00, 8'h00, 4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 65535)), $urandom_range(0, 3));
`endif
        default: tick();
      endcase
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
